memory_access: RTL and testbench

MEM stage of the 5-stage MIPS pipeline: the consumer end of the EX→MEM pipeline register. It performs lw/sw through a request/acknowledge data-memory port and stalls upstream stages while an access is outstanding. It forwards ALU results, load data, destination register and write-enable to WB as the MW_* pipeline register. It also detects misaligned accesses and memory timeouts.

---
 rtl/mips_pkg.sv | 15 +
 rtl/dm_watchdog.sv | 35 +++
 rtl/memory_access.sv | 160 ++++++++++++++++
 tb/tb_memory_access.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MEM-stage FSM states, memory-op encodings, zero register.
package mips_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // {XM_RDF, XM_RDF2} encodings; XM_RDF=0 is an ALU op or bubble regardless of XM_RDF2
  localparam logic [1:0] MEMOP_SW = 2'b10;
  localparam logic [1:0] MEMOP_LW = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/dm_watchdog.sv
// Data-memory access watchdog: 8-bit cycle counter that flags the last permitted WAIT cycle.
module dm_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == LAST);

endmodule

// File: rtl/memory_access.sv
// MEM stage: lw/sw over a req/ack data-memory port, upstream stall, MW pipeline register, error flag.
module memory_access
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUout,
  input  logic [31:0] XM_WD,
  input  logic [4:0]  XM_RD,
  input  logic        XM_RDF,
  input  logic        XM_RDF2,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [29:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] MW_DATA,
  output logic [4:0]  MW_RD,
  output logic        MW_RDF,
  output logic        err
);

  state_e      state_q, state_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [29:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        ld_q, ld_d;
  logic [31:0] mw_data_q, mw_data_d;
  logic [4:0]  mw_rd_q, mw_rd_d;
  logic        mw_rdf_q, mw_rdf_d;
  logic        err_q, err_d;
  logic        stall_c;
  logic        is_ld, is_st, is_mem, aligned;
  logic        wd_clr, wd_en, wd_expire;

  dm_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_comb begin
    is_ld      = ({XM_RDF, XM_RDF2} == MEMOP_LW);
    is_st      = ({XM_RDF, XM_RDF2} == MEMOP_SW);
    is_mem     = is_ld | is_st;
    aligned    = (ALUout[1:0] == 2'b00);
    state_d    = state_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    rd_d       = rd_q;
    ld_d       = ld_q;
    mw_data_d  = mw_data_q;
    mw_rd_d    = mw_rd_q;
    mw_rdf_d   = mw_rdf_q;
    err_d      = err_q;
    stall_c    = 1'b0;
    wd_clr     = (state_q == IDLE);
    wd_en      = (state_q == WAIT);
    case (state_q)
      IDLE: begin
        if (!is_mem) begin
          mw_data_d = ALUout;
          mw_rd_d   = XM_RD;
          mw_rdf_d  = (XM_RD != REG_ZERO);
        end else begin
          mw_data_d = '0;
          mw_rd_d   = REG_ZERO;
          mw_rdf_d  = 1'b0;
          if (aligned) begin
            stall_c    = 1'b1;
            state_d    = WAIT;
            dm_req_d   = 1'b1;
            dm_we_d    = is_st;
            dm_addr_d  = ALUout[31:2];
            dm_wdata_d = XM_WD;
            rd_d       = XM_RD;
            ld_d       = is_ld;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT: begin
        // Ack takes priority over an expiring watchdog in the same cycle
        if (dm_ack) begin
          state_d  = IDLE;
          dm_req_d = 1'b0;
          if (ld_q) begin
            mw_data_d = dm_rdata;
            mw_rd_d   = rd_q;
            mw_rdf_d  = (rd_q != REG_ZERO);
          end else begin
            mw_data_d = '0;
            mw_rd_d   = REG_ZERO;
            mw_rdf_d  = 1'b0;
          end
        end else if (wd_expire) begin
          state_d   = IDLE;
          dm_req_d  = 1'b0;
          err_d     = 1'b1;
          mw_data_d = '0;
          mw_rd_d   = REG_ZERO;
          mw_rdf_d  = 1'b0;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      rd_q       <= REG_ZERO;
      ld_q       <= 1'b0;
      mw_data_q  <= '0;
      mw_rd_q    <= REG_ZERO;
      mw_rdf_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      rd_q       <= rd_d;
      ld_q       <= ld_d;
      mw_data_q  <= mw_data_d;
      mw_rd_q    <= mw_rd_d;
      mw_rdf_q   <= mw_rdf_d;
      err_q      <= err_d;
    end
  end

  assign stall    = stall_c & rst;
  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign MW_DATA  = mw_data_q;
  assign MW_RD    = mw_rd_q;
  assign MW_RDF   = mw_rdf_q;
  assign err      = err_q;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: stimulus queues expected dm requests and writebacks, monitor checks.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUout, XM_WD, dm_rdata, MW_DATA, dm_wdata;
  logic [4:0]  XM_RD, MW_RD;
  logic        XM_RDF, XM_RDF2, stall, dm_req, dm_we, dm_ack, MW_RDF, err;
  logic [29:0] dm_addr;

  int total = 0;
  int bad   = 0;

  logic [62:0] dq[$];
  logic [36:0] wq[$];
  logic [62:0] cur_dm;
  logic        req_prev = 1'b0;

  memory_access #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ALUout(ALUout), .XM_WD(XM_WD), .XM_RD(XM_RD),
    .XM_RDF(XM_RDF), .XM_RDF2(XM_RDF2), .stall(stall), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .MW_DATA(MW_DATA), .MW_RD(MW_RD), .MW_RDF(MW_RDF), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [62:0] act, input logic [62:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: dm request on rising dm_req (held stable while high), writeback whenever MW_RDF=1
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (dm_req && !req_prev) begin
        if (dq.size() == 0) chk("dm_req_unexpected", 63'(dm_req), 63'd0);
        else cur_dm = dq.pop_front();
      end
      if (dm_req) chk("dm_port", {dm_we, dm_addr, dm_wdata}, cur_dm);
      if (MW_RDF) begin
        if (wq.size() == 0) chk("wb_unexpected", {MW_DATA, MW_RD}, 63'd0);
        else chk("wb", 63'({MW_DATA, MW_RD}), 63'(wq.pop_front()));
      end
    end
    req_prev = dm_req;
  end

  task automatic idle_in();
    ALUout = '0; XM_WD = '0; XM_RD = '0; XM_RDF = 1'b0; XM_RDF2 = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic alu_op(input logic [31:0] a, input logic [4:0] rd);
    ALUout = a; XM_RD = rd; XM_RDF = 1'b0;
    if (rd != 5'd0) wq.push_back({a, rd});
    @(negedge clk); chk("alu_stall", 63'(stall), 63'd0);
    step(); idle_in();
  endtask

  // ack_at: WAIT cycle (1-based) carrying dm_ack; 0 = never ack
  task automatic mem_op(input bit ld, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd, input int ack_at, input logic [31:0] rdata,
                        output int w, output int st);
    ALUout = a; XM_WD = wd; XM_RD = rd; XM_RDF = 1'b1; XM_RDF2 = ld;
    dq.push_back({~ld, a[31:2], wd});
    if (ld && rd != 5'd0 && ack_at != 0) wq.push_back({rdata, rd});
    st = 0; w = 0;
    @(negedge clk); if (stall) st++;
    step();
    while (dm_req && w < 300) begin
      w++;
      dm_ack = (w == ack_at); dm_rdata = rdata;
      @(negedge clk); if (stall) st++;
      if (!dm_ack) chk("wait_mw_bubble", 63'(MW_RDF), 63'd0);
      step();
      dm_ack = 1'b0;
    end
    if (w >= 300) chk("wait_bound", 63'(w), 63'd0);
    idle_in();
  endtask

  int w, st;

  initial begin
    rst = 1'b0; dm_ack = 1'b0; dm_rdata = '0; idle_in();
    repeat (2) @(posedge clk); #1;
    chk("reset_outs", {stall, dm_req, dm_we, dm_addr, MW_RDF, err}, 63'd0);
    chk("reset_data", 63'({dm_wdata, MW_DATA}), 63'd0);
    chk("reset_rd", 63'(MW_RD), 63'd0);
    rst = 1'b1;
    step();

    alu_op(32'h1234, 5'd5);
    alu_op(32'h5555, 5'd0);
    step();

    mem_op(1'b0, 32'h40, 32'hDEADBEEF, 5'd3, 4, 32'h0, w, st);
    chk("sw_wait_cycles", 63'(w), 63'd4);
    chk("sw_stall_cycles", 63'(st), 63'd4);

    mem_op(1'b1, 32'h80, 32'h0, 5'd8, 1, 32'hCAFEF00D, w, st);
    chk("lw_wait_cycles", 63'(w), 63'd1);
    chk("lw_stall_cycles", 63'(st), 63'd1);
    step();

    mem_op(1'b1, 32'h84, 32'h0, 5'd0, 2, 32'h11111111, w, st);
    chk("lw_r0_stall", 63'(st), 63'd2);
    chk("err_clean", 63'(err), 63'd0);
    step();

    ALUout = 32'h82; XM_RD = 5'd6; XM_RDF = 1'b1; XM_RDF2 = 1'b1;
    @(negedge clk); chk("misalign_stall", 63'(stall), 63'd0);
    step(); idle_in();
    chk("misalign_flags", {dm_req, MW_RDF, err}, 63'b001);
    step();
    chk("err_sticky", 63'(err), 63'd1);

    rst = 1'b0; step(); rst = 1'b1; step();
    chk("err_cleared", 63'(err), 63'd0);

    mem_op(1'b1, 32'h100, 32'h0, 5'd7, 0, 32'h0, w, st);
    chk("to_wait_cycles", 63'(w), 63'd4);
    chk("to_stall_cycles", 63'(st), 63'd4);
    chk("to_flags", {dm_req, MW_RDF, err}, 63'b001);
    dm_ack = 1'b1; dm_rdata = 32'hBADBAD00;
    step(); dm_ack = 1'b0;
    chk("late_ack_ignored", {dm_req, MW_RDF, stall}, 63'd0);
    step();

    rst = 1'b0; step(); rst = 1'b1; step();
    ALUout = 32'h200; XM_RD = 5'd4; XM_RDF = 1'b1; XM_RDF2 = 1'b1;
    dq.push_back({1'b0, 30'h80, 32'h0});
    step(); step(); #2;
    rst = 1'b0; #1;
    chk("midwait_rst_req", {dm_req, dm_we, stall, MW_RDF, err}, 63'd0);
    chk("midwait_rst_data", {dm_addr, MW_DATA}, 63'd0);
    idle_in();
    step(); rst = 1'b1; step();

    mem_op(1'b1, 32'h300, 32'h0, 5'd9, 2, 32'h12345678, w, st);
    chk("post_rst_lw_stall", 63'(st), 63'd2);
    step(); step();
    chk("dq_drained", 63'(dq.size()), 63'd0);
    chk("wq_drained", 63'(wq.size()), 63'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
